// File: rtl/uio_arb_pkg.sv
// Shared types, default parameters and width helper for the uio pad-bus arbiter.
package uio_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TURN = 2'd1,
    OWN  = 2'd2
  } arb_state_e;

  localparam int unsigned N_REQ_DEF    = 4;
  localparam int unsigned MAX_HOLD_DEF = 16;
  localparam int unsigned TURN_CYC_DEF = 1;

  // Bits needed to hold values 0..v-1; counters call it with (max + 1).
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (longint unsigned p = 1; p < longint'(v); p = p * 2) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/uio_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req_i at or after ptr_i, wrapping.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_oh_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  always_comb begin
    int unsigned j;
    gnt_oh_o = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    j        = 0;
    for (int unsigned k = 0; k < N; k++) begin
      j = (32'(ptr_i) + k) % N;
      if (!valid_o && req_i[j]) begin
        valid_o     = 1'b1;
        idx_o       = IW'(j);
        gnt_oh_o[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uio_bus_arbiter.sv
// Round-robin owner of the shared uio pad bus with a forced all-oe-low turnaround
// before every grant and hold-budget preemption when other requesters wait.
module uio_bus_arbiter
  import uio_arb_pkg::*;
#(
  parameter int unsigned N_REQ    = N_REQ_DEF,
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEF,
  parameter int unsigned TURN_CYC = TURN_CYC_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_out,
  input  logic [8*N_REQ-1:0] req_oe,
  output logic [N_REQ-1:0]   gnt,
  output logic               busy,
  output logic [7:0]         rdata,
  output logic [7:0]         uio_out,
  output logic [7:0]         uio_oe,
  input  logic [7:0]         uio_in
);

  localparam int unsigned IW  = clog2(N_REQ);
  localparam int unsigned HCW = clog2(MAX_HOLD + 1);
  localparam int unsigned TCW = clog2(TURN_CYC + 1);

  localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAX_HOLD - 1);
  localparam logic [HCW-1:0] HOLD_SAT  = HCW'(MAX_HOLD);
  localparam logic [TCW-1:0] TURN_LOAD = TCW'(TURN_CYC - 1);
  localparam logic [IW-1:0]  LAST_IDX  = IW'(N_REQ - 1);

  arb_state_e       state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    tgt_q, tgt_d;
  logic [N_REQ-1:0] tgt_oh_q, tgt_oh_d;
  logic [TCW-1:0]   turn_q, turn_d;
  logic [HCW-1:0]   hold_q, hold_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [7:0]       uio_out_q, uio_out_d;
  logic [7:0]       uio_oe_q, uio_oe_d;
  logic [7:0]       rdata_q;

  logic [N_REQ-1:0] idle_oh, pre_oh;
  logic [IW-1:0]    idle_idx, pre_idx, tgt_next;
  logic             idle_valid, pre_valid, tgt_req;

  assign tgt_next = (tgt_q == LAST_IDX) ? '0 : tgt_q + 1'b1;
  assign tgt_req  = |(req & tgt_oh_q);

  rr_pick #(.N(N_REQ), .IW(IW)) u_pick_idle (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .gnt_oh_o (idle_oh),
    .idx_o    (idle_idx),
    .valid_o  (idle_valid)
  );

  // Preemption search excludes the current owner and starts just past it.
  rr_pick #(.N(N_REQ), .IW(IW)) u_pick_pre (
    .req_i    (req & ~tgt_oh_q),
    .ptr_i    (tgt_next),
    .gnt_oh_o (pre_oh),
    .idx_o    (pre_idx),
    .valid_o  (pre_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      tgt_q     <= '0;
      tgt_oh_q  <= '0;
      turn_q    <= '0;
      hold_q    <= '0;
      gnt_q     <= '0;
      uio_out_q <= '0;
      uio_oe_q  <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      tgt_q     <= tgt_d;
      tgt_oh_q  <= tgt_oh_d;
      turn_q    <= turn_d;
      hold_q    <= hold_d;
      gnt_q     <= gnt_d;
      uio_out_q <= uio_out_d;
      uio_oe_q  <= uio_oe_d;
      rdata_q   <= uio_in;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    tgt_d    = tgt_q;
    tgt_oh_d = tgt_oh_q;
    turn_d   = turn_q;
    hold_d   = hold_q;
    if (!ena) begin
      state_d = IDLE;
      turn_d  = '0;
      hold_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (idle_valid) begin
            state_d  = TURN;
            tgt_d    = idle_idx;
            tgt_oh_d = idle_oh;
            turn_d   = TURN_LOAD;
          end
        end
        TURN: begin
          if (turn_q == '0) begin
            if (tgt_req) begin
              state_d = OWN;
              hold_d  = '0;
              ptr_d   = tgt_next;
            end else begin
              state_d = IDLE;
            end
          end else begin
            turn_d = turn_q - 1'b1;
          end
        end
        OWN: begin
          if (!tgt_req) begin
            state_d = IDLE;
            hold_d  = '0;
          end else if (hold_q >= HOLD_LAST && pre_valid) begin
            state_d  = TURN;
            tgt_d    = pre_idx;
            tgt_oh_d = pre_oh;
            turn_d   = TURN_LOAD;
            hold_d   = '0;
          end else if (hold_q != HOLD_SAT) begin
            hold_d = hold_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Pad registers follow the owner selected for the next cycle; any non-OWN state drives oe low.
  always_comb begin
    gnt_d     = '0;
    uio_oe_d  = '0;
    uio_out_d = uio_out_q;
    if (state_d == OWN) begin
      gnt_d     = tgt_oh_d;
      uio_out_d = req_out[8*tgt_d +: 8];
      uio_oe_d  = req_oe[8*tgt_d +: 8];
    end
  end

  assign gnt     = gnt_q;
  assign busy    = (state_q != IDLE);
  assign rdata   = rdata_q;
  assign uio_out = uio_out_q;
  assign uio_oe  = uio_oe_q;

  a_oe_only_in_own: assert property (@(posedge clk) disable iff (!rst_n)
    (uio_oe_q != '0) |-> (state_q == OWN));
  a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(gnt_q));

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Self-checking bench for uio_bus_arbiter: directed scenarios plus randomized traffic
// against a behavioural owner/gap/pointer model.
module tb_uio_bus_arbiter;

  localparam int N  = 4;
  localparam int MH = 16;
  localparam int TC = 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           ena = 1'b0;
  logic [N-1:0]   req = '0;
  logic [8*N-1:0] req_out = '0;
  logic [8*N-1:0] req_oe = '0;
  logic [7:0]     uio_in = '0;
  logic [N-1:0]   gnt;
  logic           busy;
  logic [7:0]     rdata, uio_out, uio_oe;

  int errors = 0;
  int checks = 0;

  // Model: who owns the bus (-1 none), who is waiting out a gap (-1 none).
  int         m_owner, m_target, m_gap, m_hold, m_ptr;
  logic [7:0] m_out, m_oe, m_rdata;

  uio_bus_arbiter #(
    .N_REQ    (N),
    .MAX_HOLD (MH),
    .TURN_CYC (TC)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .req     (req),
    .req_out (req_out),
    .req_oe  (req_oe),
    .gnt     (gnt),
    .busy    (busy),
    .rdata   (rdata),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .uio_in  (uio_in)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors + 1);
    $fatal(1, "watchdog");
  end

  function automatic int rr(input logic [N-1:0] mask, input int start);
    for (int k = 0; k < N; k++)
      if (mask[(start + k) % N]) return (start + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] m_gnt();
    logic [N-1:0] e;
    e = '0;
    if (m_owner >= 0) e[m_owner] = 1'b1;
    return e;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_target = -1; m_gap = 0; m_hold = 0; m_ptr = 0;
    m_out = '0; m_oe = '0; m_rdata = '0;
  endtask

  task automatic model_step();
    logic [N-1:0] others;
    m_rdata = uio_in;
    if (!ena) begin
      m_owner = -1; m_target = -1; m_gap = 0; m_hold = 0; m_oe = '0;
    end else if (m_owner >= 0) begin
      others = req;
      others[m_owner] = 1'b0;
      if (!req[m_owner]) begin
        m_owner = -1; m_hold = 0; m_oe = '0;
      end else if (m_hold >= MH - 1 && others != '0) begin
        m_target = rr(others, (m_owner + 1) % N);
        m_owner = -1; m_gap = TC; m_hold = 0; m_oe = '0;
      end else begin
        m_out = req_out[8*m_owner +: 8];
        m_oe  = req_oe[8*m_owner +: 8];
        if (m_hold < MH) m_hold++;
      end
    end else if (m_target >= 0) begin
      m_gap--;
      if (m_gap == 0) begin
        if (req[m_target]) begin
          m_owner = m_target;
          m_ptr   = (m_target + 1) % N;
          m_hold  = 0;
          m_out   = req_out[8*m_owner +: 8];
          m_oe    = req_oe[8*m_owner +: 8];
        end
        m_target = -1;
      end
    end else if (req != '0) begin
      m_target = rr(req, m_ptr);
      m_gap    = TC;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ena = 1'b1; req = '0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    ena = 1'b1; req = 4'b1111; req_out = {4{8'h5A}}; req_oe = '1; uio_in = 8'h3C;
    rst_n = 1'b0;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
      checks++; if (uio_oe !== 8'h00) begin errors++; $display("FAIL reset_oe: got %h expected 00", uio_oe); end
      checks++; if (uio_out !== 8'h00) begin errors++; $display("FAIL reset_out: got %h expected 00", uio_out); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h expected 00", rdata); end
    end
    rst_n = 1'b1;
    tick();
    checks++; if (gnt !== 4'b0000 || busy !== 1'b1) begin errors++; $display("FAIL reset_turn: got gnt=%b busy=%b expected gnt=0000 busy=1", gnt, busy); end
    checks++; if (rdata !== 8'h3C) begin errors++; $display("FAIL reset_rdata_follow: got %h expected 3c", rdata); end
    tick();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL reset_first_grant: got %b expected 0001", gnt); end
    checks++; if (uio_oe !== 8'hFF || uio_out !== 8'h5A) begin errors++; $display("FAIL reset_first_pad: got oe=%h out=%h expected oe=ff out=5a", uio_oe, uio_out); end
    // Asynchronous reset while owning: pads must release without a clock edge.
    rst_n = 1'b0;
    #2;
    model_reset();
    checks++; if (uio_oe !== 8'h00 || gnt !== 4'b0000) begin errors++; $display("FAIL async_reset_release: got oe=%h gnt=%b expected oe=00 gnt=0000", uio_oe, gnt); end
    checks++; if (busy !== 1'b0 || uio_out !== 8'h00) begin errors++; $display("FAIL async_reset_state: got busy=%b out=%h expected busy=0 out=00", busy, uio_out); end
    req = '0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    req_out = $urandom; req_out[23:16] = 8'hA5;
    req_oe  = $urandom; req_oe[23:16]  = 8'hF0;
    req = 4'b0100;
    tick(); tick();
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt: got %b expected 0100", gnt); end
    checks++; if (uio_oe !== 8'hF0) begin errors++; $display("FAIL single_oe: got %h expected f0", uio_oe); end
    checks++; if (uio_out !== 8'hA5) begin errors++; $display("FAIL single_out: got %h expected a5", uio_out); end
    req_out[23:16] = 8'h3C; req_oe[23:16] = 8'h0F;
    tick();
    checks++; if (uio_out !== 8'h3C || uio_oe !== 8'h0F) begin errors++; $display("FAIL single_lag: got out=%h oe=%h expected out=3c oe=0f", uio_out, uio_oe); end
    req = '0;
    tick();
    checks++; if (gnt !== 4'b0000 || uio_oe !== 8'h00 || busy !== 1'b0) begin errors++; $display("FAIL single_release: got gnt=%b oe=%h busy=%b expected 0000/00/0", gnt, uio_oe, busy); end
  endtask

  task automatic test_preempt();
    logic [N-1:0] e;
    int own;
    do_reset();
    req_oe = '1; req_out = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    req = 4'b1001;
    tick(); tick();
    for (int r = 0; r < 4; r++) begin
      own = (r % 2 == 0) ? 0 : 3;
      e = 4'(1 << own);
      for (int c = 0; c < MH; c++) begin
        checks++; if (gnt !== e) begin errors++; $display("FAIL preempt_hold r%0d c%0d: got %b expected %b", r, c, gnt, e); end
        checks++; if (uio_out !== req_out[8*own +: 8] || uio_oe !== 8'hFF) begin errors++; $display("FAIL preempt_pad r%0d c%0d: got out=%h oe=%h", r, c, uio_out, uio_oe); end
        tick();
      end
      checks++; if (gnt !== 4'b0000 || uio_oe !== 8'h00 || busy !== 1'b1) begin errors++; $display("FAIL preempt_gap r%0d: got gnt=%b oe=%h busy=%b expected 0000/00/1", r, gnt, uio_oe, busy); end
      tick();
    end
    req = '0;
    tick(); tick();
  endtask

  task automatic test_lone_hold();
    do_reset();
    req_oe = '0; req_oe[15:8] = 8'h0F;
    req = 4'b0010;
    tick(); tick();
    for (int c = 0; c < 50; c++) begin
      checks++; if (gnt !== 4'b0010 || uio_oe !== 8'h0F) begin errors++; $display("FAIL lone_hold c%0d: got gnt=%b oe=%h expected 0010/0f", c, gnt, uio_oe); end
      tick();
    end
    req = '0;
    tick();
  endtask

  task automatic test_turn_drop();
    do_reset();
    req = 4'b0010;
    tick(); tick();
    req = '0;
    tick();
    req = 4'b1000;
    tick();
    checks++; if (busy !== 1'b1 || gnt !== 4'b0000) begin errors++; $display("FAIL drop_turn: got busy=%b gnt=%b expected 1/0000", busy, gnt); end
    req = '0;
    tick();
    checks++; if (busy !== 1'b0 || gnt !== 4'b0000 || uio_oe !== 8'h00) begin errors++; $display("FAIL drop_idle: got busy=%b gnt=%b oe=%h expected 0/0000/00", busy, gnt, uio_oe); end
    req = 4'b0111;
    tick(); tick();
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL drop_ptr_kept: got %b expected 0100", gnt); end
    req = '0;
    tick();
  endtask

  task automatic test_ena();
    do_reset();
    req_oe = '1; req_out = '0; req_out[15:8] = 8'h77;
    req = 4'b0010;
    tick(); tick();
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL ena_grant: got %b expected 0010", gnt); end
    ena = 1'b0;
    tick();
    checks++; if (gnt !== 4'b0000 || uio_oe !== 8'h00 || busy !== 1'b0) begin errors++; $display("FAIL ena_drop: got gnt=%b oe=%h busy=%b expected 0000/00/0", gnt, uio_oe, busy); end
    checks++; if (uio_out !== 8'h77) begin errors++; $display("FAIL ena_out_held: got %h expected 77", uio_out); end
    req = 4'b1111;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ena_idle_hold: got busy=%b expected 0", busy); end
    ena = 1'b1;
    tick(); tick();
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL ena_restart_ptr: got %b expected 0100", gnt); end
    req = '0;
    tick();
  endtask

  task automatic test_random();
    logic [N-1:0] eg;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 15) == 0) req[b] = ~req[b];
      req_out = 32'($urandom);
      req_oe  = 32'($urandom);
      uio_in  = 8'($urandom);
      ena     = ($urandom_range(0, 99) != 0);
      tick();
      eg = m_gnt();
      checks++; if (gnt !== eg) begin errors++; $display("FAIL rand_gnt c%0d: got %b expected %b", c, gnt, eg); end
      checks++; if (uio_oe !== m_oe) begin errors++; $display("FAIL rand_oe c%0d: got %h expected %h", c, uio_oe, m_oe); end
      checks++; if (uio_out !== m_out) begin errors++; $display("FAIL rand_out c%0d: got %h expected %h", c, uio_out, m_out); end
      checks++; if (busy !== (m_owner >= 0 || m_target >= 0)) begin errors++; $display("FAIL rand_busy c%0d: got %b expected %b", c, busy, (m_owner >= 0 || m_target >= 0)); end
      checks++; if (rdata !== m_rdata) begin errors++; $display("FAIL rand_rdata c%0d: got %h expected %h", c, rdata, m_rdata); end
    end
    ena = 1'b1; req = '0;
    tick();
  endtask

  initial begin
    model_reset();
    #1;
    test_reset();
    test_single();
    test_preempt();
    test_lone_hold();
    test_turn_drop();
    test_ena();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
